// File: rtl/dust_alarm_judge_pkg.sv
// dust_alarm_judge_pkg: shared widths, watchdog default and alarm FSM encoding
package dust_alarm_judge_pkg;
  localparam int CNT_W_D = 10;
  localparam int REV_W_D = 4;
  localparam int TMO_W_D = 24;
  // 50 MHz clock, rotor never slower than 5 rev/s
  localparam int CLK_HZ = 50_000_000;
  localparam int MIN_RPS = 5;
  localparam int TMO_CYCLES_D = CLK_HZ / MIN_RPS;
  typedef enum logic [1:0] {NORMAL, PEND_ON, ALARM, PEND_OFF} state_t;
endpackage

// File: rtl/dust_alarm_judge_watchdog.sv
// rev_watchdog: flags a stalled motor when no zero_flag arrives for TMO_CYCLES clocks
module rev_watchdog #(
  parameter int TMO_W = 24,
  parameter int TMO_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic zero_flag,
  output logic stall
);
  localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYCLES - 1);
  logic [TMO_W-1:0] tmo;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo <= '0;
      stall <= 1'b0;
    end else if (zero_flag) begin
      tmo <= '0;
      stall <= 1'b0;
    end else if (tmo == LAST) begin
      stall <= 1'b1;
    end else begin
      tmo <= tmo + 1'b1;
    end
  end
endmodule

// File: rtl/dust_alarm_judge.sv
// dust_alarm_judge: hysteresis + debounced dust alarm, peak tracker and motor stall watchdog
module dust_alarm_judge
  import dust_alarm_judge_pkg::*;
#(
  parameter int CNT_W = CNT_W_D,
  parameter int REV_W = REV_W_D,
  parameter int TMO_W = TMO_W_D,
  parameter int TMO_CYCLES = TMO_CYCLES_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             zero_flag,
  input  logic [CNT_W-1:0] dust_cnt,
  input  logic [CNT_W-1:0] alarm_on_level,
  input  logic [CNT_W-1:0] alarm_off_level,
  input  logic [REV_W-1:0] on_revs,
  input  logic [REV_W-1:0] off_revs,
  input  logic             clr_peak,
  output logic             dust_alarm,
  output logic             alarm_pulse,
  output logic             rev_valid,
  output logic [CNT_W-1:0] peak_cnt,
  output logic             motor_stall
);
  localparam logic [REV_W-1:0] ONE = REV_W'(1);
  state_t state, nxt;
  logic [REV_W-1:0] pend, pn, pinc, eff_on, eff_off;
  logic [REV_W:0] pend1;
  logic [CNT_W-1:0] clean_lvl;
  logic zf_d, first_rev, stall_zf, accept, dirty, clean, reach_on, reach_off, nalarm;

  rev_watchdog #(.TMO_W(TMO_W), .TMO_CYCLES(TMO_CYCLES)) u_wd (
    .clk(clk), .rst(rst), .zero_flag(zero_flag), .stall(motor_stall)
  );

  always_comb begin
    accept = zf_d && !first_rev && !stall_zf;
    eff_on = (on_revs == '0) ? ONE : on_revs;
    eff_off = (off_revs == '0) ? ONE : off_revs;
    // clamping the clean level below the dirty level keeps the two classes disjoint
    clean_lvl = (alarm_off_level < alarm_on_level) ? alarm_off_level : alarm_on_level;
    dirty = dust_cnt >= alarm_on_level;
    clean = dust_cnt < clean_lvl;
    pend1 = {1'b0, pend} + 1'b1;
    pinc = (&pend) ? pend : pend1[REV_W-1:0];
    reach_on = pend1 >= {1'b0, eff_on};
    reach_off = pend1 >= {1'b0, eff_off};
    nxt = state;
    pn = pend;
    case (state)
      NORMAL: if (dirty) begin
        nxt = (eff_on == ONE) ? ALARM : PEND_ON;
        pn = (eff_on == ONE) ? '0 : ONE;
      end
      PEND_ON: if (dirty) begin
        nxt = reach_on ? ALARM : PEND_ON;
        pn = reach_on ? '0 : pinc;
      end else if (clean) begin
        nxt = NORMAL;
        pn = '0;
      end
      ALARM: if (clean) begin
        nxt = (eff_off == ONE) ? NORMAL : PEND_OFF;
        pn = (eff_off == ONE) ? '0 : ONE;
      end
      PEND_OFF: if (clean) begin
        nxt = reach_off ? NORMAL : PEND_OFF;
        pn = reach_off ? '0 : pinc;
      end else if (dirty) begin
        nxt = ALARM;
        pn = '0;
      end
      default: nxt = NORMAL;
    endcase
    nalarm = (nxt == ALARM) || (nxt == PEND_OFF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= NORMAL;
      pend <= '0;
      zf_d <= 1'b0;
      first_rev <= 1'b1;
      stall_zf <= 1'b0;
      dust_alarm <= 1'b0;
      alarm_pulse <= 1'b0;
      rev_valid <= 1'b0;
      peak_cnt <= '0;
    end else begin
      zf_d <= zero_flag;
      if (zero_flag) stall_zf <= motor_stall;
      if (zf_d) first_rev <= 1'b0;
      rev_valid <= accept;
      alarm_pulse <= 1'b0;
      if (accept) begin
        state <= nxt;
        pend <= pn;
        dust_alarm <= nalarm;
        alarm_pulse <= nalarm && !dust_alarm;
        peak_cnt <= (clr_peak || dust_cnt > peak_cnt) ? dust_cnt : peak_cnt;
      end else begin
        if (clr_peak) peak_cnt <= '0;
        if (motor_stall) pend <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dust_alarm_judge.sv
// tb_dust_alarm_judge: directed revolutions with hand-computed alarm, peak and stall expectations
module tb_dust_alarm_judge;
  logic clk = 1'b0, rst = 1'b1, zero_flag = 1'b0, clr_peak = 1'b0;
  logic [9:0] dust_cnt = '0, alarm_on_level = '0, alarm_off_level = '0;
  logic [3:0] on_revs = '0, off_revs = '0;
  logic dust_alarm, alarm_pulse, rev_valid, motor_stall;
  logic [9:0] peak_cnt;
  int n_chk = 0, n_fail = 0;

  dust_alarm_judge #(.TMO_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .zero_flag(zero_flag), .dust_cnt(dust_cnt),
    .alarm_on_level(alarm_on_level), .alarm_off_level(alarm_off_level),
    .on_revs(on_revs), .off_revs(off_revs), .clr_peak(clr_peak),
    .dust_alarm(dust_alarm), .alarm_pulse(alarm_pulse), .rev_valid(rev_valid),
    .peak_cnt(peak_cnt), .motor_stall(motor_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rev(input int cnt, input bit clr, input bit exp_v);
    zero_flag = 1'b1;
    dust_cnt = 10'(cnt);
    @(posedge clk);
    #1 zero_flag = 1'b0;
    clr_peak = clr;
    @(posedge clk);
    #1 clr_peak = 1'b0;
    chk("rev_valid", int'(rev_valid), int'(exp_v));
  endtask

  task automatic pulse_seen();
    chk("alarm_pulse_hi", int'(alarm_pulse), 1);
    idle(1);
    chk("alarm_pulse_lo", int'(alarm_pulse), 0);
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    chk("rst_alarm", int'(dust_alarm), 0);
    chk("rst_pulse", int'(alarm_pulse), 0);
    chk("rst_valid", int'(rev_valid), 0);
    chk("rst_peak", int'(peak_cnt), 0);
    chk("rst_stall", int'(motor_stall), 0);
    alarm_on_level = 10'd100; alarm_off_level = 10'd50; on_revs = 4'd3; off_revs = 4'd2;
    rev(500, 0, 0);
    chk("first_alarm", int'(dust_alarm), 0);
    chk("first_peak", int'(peak_cnt), 0);
    idle(2);
    rev(120, 0, 1); chk("on1", int'(dust_alarm), 0); idle(2);
    rev(130, 0, 1); chk("on2", int'(dust_alarm), 0); idle(2);
    rev(150, 0, 1); chk("on3", int'(dust_alarm), 1);
    pulse_seen();
    chk("peak150", int'(peak_cnt), 150);
    idle(2);
    rev(70, 0, 1); chk("band1", int'(dust_alarm), 1); idle(2);
    rev(70, 0, 1); chk("band2", int'(dust_alarm), 1); idle(2);
    rev(40, 0, 1); chk("off1", int'(dust_alarm), 1); idle(2);
    rev(40, 0, 1); chk("off2", int'(dust_alarm), 0); idle(2);
    rev(120, 0, 1); idle(2);
    rev(30, 0, 1); idle(2);
    rev(120, 0, 1); chk("broken_run", int'(dust_alarm), 0);
    chk("broken_pulse", int'(alarm_pulse), 0); idle(2);
    rev(30, 0, 1); idle(2);
    clr_peak = 1'b1; idle(1); clr_peak = 1'b0;
    chk("clr_alone", int'(peak_cnt), 0);
    rev(30, 0, 1); idle(2);
    rev(80, 0, 1); idle(2);
    rev(60, 0, 1); chk("peak80", int'(peak_cnt), 80); idle(2);
    rev(10, 1, 1); chk("clr_with_sample", int'(peak_cnt), 10);
    chk("clr_alarm", int'(dust_alarm), 0); idle(2);
    on_revs = 4'd0;
    rev(100, 0, 1); chk("on_revs0", int'(dust_alarm), 1);
    pulse_seen(); idle(2);
    alarm_on_level = 10'd50; alarm_off_level = 10'd200; off_revs = 4'd1;
    rev(49, 0, 1); chk("inv_clean", int'(dust_alarm), 0); idle(2);
    rev(100, 0, 1); chk("inv_dirty", int'(dust_alarm), 1);
    idle(60);
    chk("no_stall_yet", int'(motor_stall), 0);
    idle(60);
    chk("stall", int'(motor_stall), 1);
    chk("stall_hold", int'(dust_alarm), 1);
    rev(20, 0, 0);
    chk("stall_clr", int'(motor_stall), 0);
    chk("stall_discard", int'(dust_alarm), 1); idle(2);
    rev(20, 0, 1); chk("post_stall", int'(dust_alarm), 0);
    chk("post_peak", int'(peak_cnt), 100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dust_alarm_judge.md
Name: dust_alarm_judge

Overview:
- Sits directly downstream of the per-revolution dust counter stage. It consumes the latched dust count (one value per revolution, framed by zero_flag).
- Applies hysteresis and N-consecutive-revolution debouncing to decide a stable window-contamination alarm.
- Tracks the peak count and flags a stalled motor when revolutions stop arriving.
- Outputs go to the status/register block and the alarm I/O pin.

Parameters:
- CNT_W, 10, width of dust_cnt and level inputs.
- REV_W, 4, width of revolution debounce counters and on_revs/off_revs.
- TMO_W, 24, width of the stall watchdog counter.
- TMO_CYCLES, 10000000, clk cycles without zero_flag before motor_stall asserts.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- zero_flag  in  1  one-cycle pulse at revolution start; dust_cnt is updated on the same edge and is valid from the following cycle
- dust_cnt  in  CNT_W  dust point count of the revolution just finished
- alarm_on_level  in  CNT_W  count at or above which a revolution is "dirty"
- alarm_off_level  in  CNT_W  count below which a revolution is "clean"
- on_revs  in  REV_W  consecutive dirty revolutions needed to raise the alarm (0 treated as 1)
- off_revs  in  REV_W  consecutive clean revolutions needed to clear the alarm (0 treated as 1)
- clr_peak  in  1  single-cycle pulse that clears peak_cnt
- dust_alarm  out  1  debounced alarm level
- alarm_pulse  out  1  one-cycle pulse on each 0->1 transition of dust_alarm
- rev_valid  out  1  one-cycle pulse when a revolution sample is accepted
- peak_cnt  out  CNT_W  maximum accepted dust_cnt since reset or clr_peak
- motor_stall  out  1  watchdog expired; no zero_flag seen

Behaviour:
- Reset: all outputs 0. FSM = NORMAL. All counters 0. first_rev = 1.
- Sample strobe: zf_d = zero_flag delayed one clk. The sample is taken on the zf_d cycle.
- The sample is discarded, with no rev_valid and no FSM or peak update, when either of these holds:
  - first_rev = 1 (partial revolution after reset or stall); this clears first_rev.
  - motor_stall was 1 at the zero_flag.
- An accepted sample sets rev_valid = 1 in the cycle after zf_d. Latency from zero_flag to rev_valid or to an FSM update is 2 cycles.
- Classification, unsigned compares:
  - dirty = cnt >= alarm_on_level.
  - clean = cnt < min(alarm_off_level, alarm_on_level). This clamp guards against an inverted configuration.
  - Neither (band) means hold: the state and the pending counter are unchanged.
- FSM, evaluated only on accepted samples:
  - NORMAL: dirty -> PEND_ON, pend = 1. If eff_on_revs == 1, go directly to ALARM.
  - PEND_ON:
    - dirty: pend + 1. When pend + 1 == eff_on_revs -> ALARM.
    - clean -> NORMAL, pend = 0.
  - ALARM: clean -> PEND_OFF, pend = 1. If eff_off_revs == 1, go directly to NORMAL.
  - PEND_OFF:
    - clean: pend + 1. When pend + 1 == eff_off_revs -> NORMAL.
    - dirty -> ALARM, pend = 0.
  - dust_alarm = 1 in ALARM and PEND_OFF; registered, so it updates with rev_valid.
  - pend saturates at its maximum and never wraps.
- alarm_pulse: one cycle, coincident with the dust_alarm rising edge.
- peak_cnt:
  - Accepted sample: peak = max(peak, cnt).
  - clr_peak alone: peak = 0.
  - clr_peak together with an accepted sample: peak = cnt.
- Watchdog:
  - tmo counts up every cycle and resets to 0 on zero_flag.
  - When tmo reaches TMO_CYCLES-1: motor_stall = 1, tmo saturates, pend = 0.
  - The FSM keeps its state and dust_alarm holds.
  - The next zero_flag clears motor_stall and tmo, and that revolution is discarded.
  - zero_flag in the same cycle as expiry: zero_flag wins and motor_stall stays 0.
- Config inputs are sampled at the classification cycle. Changing them mid-revolution is legal.

Decomposition:
- Shared package holds:
  - FSM state encoding (NORMAL, PEND_ON, ALARM, PEND_OFF).
  - Default widths CNT_W, REV_W, TMO_W.
  - TMO_CYCLES default, derived from clk frequency and minimum rotor speed.
- The watchdog is a natural sub-module: rev_watchdog (counter, saturate, stall flag, clear on zero_flag). The FSM and peak tracker stay in the top module.

Test Plan:
- Reset, then zero_flag with dust_cnt = 500 at on = 100 -> sample discarded: no rev_valid, dust_alarm = 0, peak_cnt = 0.
- on = 100, off = 50, on_revs = 3; counts 120, 130, 150 -> dust_alarm rises 2 cycles after the 3rd zero_flag, alarm_pulse for one cycle; counts 120, 30, 120 instead -> no alarm.
- Hysteresis: in ALARM with off_revs = 2; counts 70, 70 (band) -> alarm holds; counts 40, 40 -> dust_alarm falls 2 cycles after the 2nd zero_flag.
- on_revs = 0, on = 100; a single count of 100 -> alarm is raised. Inverted config on = 50, off = 200; count 100 -> dirty, and count 49 -> clean.
- Peak: counts 30, 80, 60 -> peak_cnt = 80. clr_peak on the accepted-sample cycle of count 10 -> peak_cnt = 10.
- TMO_CYCLES = 100 for the bench: no zero_flag for 100 cycles -> motor_stall = 1 and dust_alarm held. The next zero_flag clears the stall with no rev_valid. The following revolution is accepted normally.
